// File: rtl/fetch_issue_ctrl_if.sv
// Bus bundle between the fetch/issue sequencer and its surroundings:
// instruction memory, decoder, execution units and trap observers.
interface fetch_issue_ctrl_if;
    // Instruction memory
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    // Decoder
    logic [31:0] inst;
    logic [11:0] code;
    // Execution unit start pulses and completion
    logic        alu_en;
    logic        mul_en;
    logic        lsu_en;
    logic        br_en;
    logic        sys_en;
    logic        unit_done;
    logic        br_taken;
    logic [31:0] br_target;
    // Architectural status
    logic [31:0] pc;
    logic        trap;
    logic [31:0] epc;
    logic [1:0]  cause;

    // Sequencer side
    modport master (
        output mem_req, mem_addr, inst,
        output alu_en, mul_en, lsu_en, br_en, sys_en,
        output pc, trap, epc, cause,
        input  mem_rdy, mem_rdata, code,
        input  unit_done, br_taken, br_target
    );

    // Environment side
    modport slave (
        input  mem_req, mem_addr, inst,
        input  alu_en, mul_en, lsu_en, br_en, sys_en,
        input  pc, trap, epc, cause,
        output mem_rdy, mem_rdata, code,
        output unit_done, br_taken, br_target
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: fetches an instruction, waits out the decoder's
// registered latency, issues a single-cycle start pulse to one execution
// unit, waits for completion and advances/redirects the PC. Illegal codes,
// misaligned branch targets and hung units trap to TRAP_VEC.
module fetch_issue_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic                clk,
    input logic                rstn,
    fetch_issue_ctrl_if.master bus
);

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [11:0] CODE_ILLEGAL = 12'hFFF;
    // Watchdog value in the last WAIT cycle that may still accept unit_done;
    // without completion in that cycle the watchdog reaches TIMEOUT and traps.
    localparam logic [7:0]  WD_LAST      = 8'(TIMEOUT - 1);

    localparam logic [1:0]  CAUSE_ILLEGAL   = 2'd0;
    localparam logic [1:0]  CAUSE_MISALIGN  = 2'd1;
    localparam logic [1:0]  CAUSE_WATCHDOG  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DEC,
        S_ISSUE,
        S_WAIT,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        U_ILLEGAL,
        U_ALU,
        U_MUL,
        U_LSU,
        U_BR,
        U_SYS
    } unit_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        mem_req_q, mem_req_d;
    logic [7:0]  wd_q, wd_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;

    unit_t       unit;
    logic        fetch_hs;
    logic        take_trap;
    logic [1:0]  trap_cause;
    logic        alu_en, mul_en, lsu_en, br_en, sys_en;
    logic        trap_pulse;

    assign fetch_hs = (state_q == S_FETCH) && mem_req_q && bus.mem_rdy;

    // Classify the registered decoder code into its target execution unit.
    always_comb begin
        unit = U_ILLEGAL;
        if (bus.code != CODE_ILLEGAL) begin
            case (bus.code[6:0])
                7'b0110011:             unit = bus.code[10] ? U_MUL : U_ALU;
                7'b0010011,
                7'b0110111,
                7'b0010111:             unit = U_ALU;
                7'b0000011,
                7'b0100011:             unit = U_LSU;
                7'b1101111,
                7'b1100111,
                7'b1100011:             unit = U_BR;
                7'b1110011,
                7'b0011000:             unit = U_SYS;
                default:                unit = U_ILLEGAL;
            endcase
        end
    end

    // Next-state, datapath updates and single-cycle output pulses.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        wd_d       = wd_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        take_trap  = 1'b0;
        trap_cause = CAUSE_ILLEGAL;
        alu_en     = 1'b0;
        mul_en     = 1'b0;
        lsu_en     = 1'b0;
        br_en      = 1'b0;
        sys_en     = 1'b0;
        trap_pulse = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (fetch_hs) begin
                    inst_d  = bus.mem_rdata;
                    state_d = S_DEC;
                end
            end

            S_DEC: begin
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
                case (unit)
                    U_ALU:   alu_en = 1'b1;
                    U_MUL:   mul_en = 1'b1;
                    U_LSU:   lsu_en = 1'b1;
                    U_BR:    br_en  = 1'b1;
                    U_SYS:   sys_en = 1'b1;
                    default: begin
                        take_trap  = 1'b1;
                        trap_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_WAIT: begin
                wd_d = wd_q + 8'd1;
                // Completion is checked before the watchdog so that a
                // unit_done in the expiry cycle still retires normally.
                if (bus.unit_done) begin
                    if (bus.br_taken) begin
                        if (bus.br_target[1:0] == 2'b00) begin
                            pc_d    = bus.br_target;
                            state_d = S_FETCH;
                        end else begin
                            take_trap  = 1'b1;
                            trap_cause = CAUSE_MISALIGN;
                        end
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                end else if (wd_q == WD_LAST) begin
                    take_trap  = 1'b1;
                    trap_cause = CAUSE_WATCHDOG;
                end
            end

            S_TRAP: begin
                trap_pulse = 1'b1;
                state_d    = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Trap entry: capture the faulting pc and cause, vector, and spend
        // one cycle in S_TRAP so the pulse coincides with updated epc/cause.
        if (take_trap) begin
            epc_d   = pc_q;
            pc_d    = TRAP_VEC;
            cause_d = trap_cause;
            state_d = S_TRAP;
        end

        // The request is registered, so it rises one cycle after reset and
        // is already high on the first FETCH cycle after WAIT or TRAP.
        mem_req_d = (state_d == S_FETCH);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            mem_req_q <= 1'b0;
            wd_q      <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            mem_req_q <= mem_req_d;
            wd_q      <= wd_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = pc_q;
    assign bus.inst     = inst_q;
    assign bus.pc       = pc_q;
    assign bus.epc      = epc_q;
    assign bus.cause    = cause_q;
    assign bus.trap     = trap_pulse;
    assign bus.alu_en   = alu_en;
    assign bus.mul_en   = mul_en;
    assign bus.lsu_en   = lsu_en;
    assign bus.br_en    = br_en;
    assign bus.sys_en   = sys_en;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Testbench for fetch_issue_ctrl: a driver plays memory, decoder and
// execution units; expected fetches, enables and traps go into a
// scoreboard queue that an independent monitor pops as the DUT emits them.
module tb_fetch_issue_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;
    localparam int unsigned TIMEOUT  = 255;

    localparam int K_ALU = 0;
    localparam int K_MUL = 1;
    localparam int K_LSU = 2;
    localparam int K_BR  = 3;
    localparam int K_SYS = 4;
    localparam int K_ILL = 5;

    typedef enum int {EV_FETCH, EV_EN, EV_TRAP} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fetch_issue_ctrl_if bif();

    fetch_issue_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    ev_t         sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_hs = -100;
    logic [31:0] m_pc;
    logic [4:0]  en_vec;

    assign en_vec = {bif.sys_en, bif.br_en, bif.lsu_en, bif.mul_en, bif.alu_en};

    // Decoder stand-in: one-cycle registered code from the held instruction.
    function automatic logic [11:0] dec_model(input logic [31:0] w);
        if (w == 32'hFFFF_FFFF) return 12'hFFF;
        return {1'b0, (w[6:0] == 7'b0110011) && w[25], w[14:12], w[6:0]};
    endfunction

    always @(posedge clk) bif.code <= dec_model(bif.inst);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm, input int budget);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen within %0d cycles (t=%0t)", nm, budget, $time);
    endtask

    function automatic void push_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        sbq.push_back(e);
    endfunction

    task automatic pop_ev(input ev_kind_t k, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{EV_FETCH, '0, '0};
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s: DUT output with empty scoreboard (t=%0t)", k.name(), $time);
            return;
        end
        e = sbq.pop_front();
        check("event_order", 32'(k), 32'(e.kind));
        ok = (e.kind == k);
    endtask

    // Monitor: compares every DUT output event with the scoreboard head.
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bif.mem_req && bif.mem_rdy) begin
                    pop_ev(EV_FETCH, e, ok);
                    if (ok) begin
                        check("fetch_addr", bif.mem_addr, e.a);
                        check("fetch_pc", bif.pc, e.b);
                    end
                    last_hs = cyc;
                end
                if (en_vec != 5'b0) begin
                    pop_ev(EV_EN, e, ok);
                    if (ok) check("enable_onehot", 32'(en_vec), e.a);
                    check("enable_latency", 32'(cyc - last_hs), 32'd2);
                end
                if (bif.trap) begin
                    pop_ev(EV_TRAP, e, ok);
                    if (ok) begin
                        check("trap_epc", bif.epc, e.a);
                        check("trap_cause", 32'(bif.cause), e.b);
                        check("trap_pc", bif.pc, TRAP_VEC);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] mk_inst(input int kind);
        logic [31:0] w;
        int          s;
        w = $urandom;
        s = $urandom_range(0, 3);
        case (kind)
            K_ALU: begin
                case (s)
                    0:       w[6:0] = 7'b0110011;
                    1:       w[6:0] = 7'b0010011;
                    2:       w[6:0] = 7'b0110111;
                    default: w[6:0] = 7'b0010111;
                endcase
                w[25] = 1'b0;
            end
            K_MUL: begin
                w[6:0] = 7'b0110011;
                w[25]  = 1'b1;
            end
            K_LSU: w[6:0] = (s[0] != 0) ? 7'b0000011 : 7'b0100011;
            K_BR: begin
                case (s)
                    0:       w[6:0] = 7'b1101111;
                    1:       w[6:0] = 7'b1100111;
                    default: w[6:0] = 7'b1100011;
                endcase
            end
            K_SYS: w[6:0] = (s[0] != 0) ? 7'b1110011 : 7'b0011000;
            default: begin
                case (s)
                    0:       w = 32'hFFFF_FFFF;
                    1:       w[6:0] = 7'b0000000;
                    2:       w[6:0] = 7'b0001111;
                    default: w[6:0] = 7'b1111011;
                endcase
            end
        endcase
        return w;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_mem_req"}, 32'(bif.mem_req), 32'd0);
        check({tag, "_pc"}, bif.pc, RESET_PC);
        check({tag, "_mem_addr"}, bif.mem_addr, RESET_PC);
        check({tag, "_inst"}, bif.inst, 32'h0000_0013);
        check({tag, "_en"}, 32'(en_vec), 32'd0);
        check({tag, "_trap"}, 32'(bif.trap), 32'd0);
        check({tag, "_epc"}, bif.epc, 32'd0);
        check({tag, "_cause"}, 32'(bif.cause), 32'd0);
    endtask

    // Fetch handshake (with random stall and ignored stray unit_done), then
    // wait for the issue cycle. Returns with got_en set when an enable fired.
    task automatic start_inst(input logic [31:0] w, input int kind, output bit got_en);
        int  stall;
        bit  seen;
        got_en = 1'b0;
        push_ev(EV_FETCH, m_pc, m_pc);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bif.mem_req) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            timeout_fail("wait_mem_req", 400);
            return;
        end
        stall = $urandom_range(0, 2);
        for (int i = 0; i < stall; i++) begin
            bif.unit_done = 1'($urandom_range(0, 1));
            bif.br_taken  = 1'b1;
            bif.br_target = $urandom;
            @(posedge clk); #1;
        end
        bif.unit_done = 1'b0;
        bif.br_taken  = 1'b0;
        bif.mem_rdy   = 1'b1;
        bif.mem_rdata = w;
        @(posedge clk); #1;
        bif.mem_rdy   = 1'b0;
        bif.mem_rdata = $urandom;
        if (kind == K_ILL) begin
            push_ev(EV_TRAP, m_pc, 32'd0);
            m_pc = TRAP_VEC;
            return;
        end
        push_ev(EV_EN, 32'(5'b1 << kind), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (en_vec != 5'b0) begin
                got_en = 1'b1;
                return;
            end
        end
        timeout_fail("wait_enable", 10);
    endtask

    // One full instruction; done is raised in WAIT cycle (dly+1), or withheld.
    task automatic run_inst(input logic [31:0] w, input int kind, input int dly,
                            input bit taken, input logic [31:0] tgt, input bit withhold);
        bit got_en;
        start_inst(w, kind, got_en);
        if (!got_en) return;
        if (withhold) begin
            push_ev(EV_TRAP, m_pc, 32'd2);
            m_pc = TRAP_VEC;
            for (int i = 1; i <= 300; i++) begin
                @(posedge clk); #1;
                if (bif.trap) begin
                    check("watchdog_latency", 32'(i), 32'(TIMEOUT + 1));
                    return;
                end
            end
            timeout_fail("wait_watchdog_trap", 300);
            return;
        end
        repeat (dly + 1) @(posedge clk);
        #1;
        bif.unit_done = 1'b1;
        bif.br_taken  = taken;
        bif.br_target = tgt;
        if (taken && tgt[1:0] == 2'b00) begin
            m_pc = tgt;
        end else if (taken) begin
            push_ev(EV_TRAP, m_pc, 32'd1);
            m_pc = TRAP_VEC;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk); #1;
        bif.unit_done = 1'b0;
        bif.br_taken  = 1'b0;
    endtask

    initial begin
        bit          got_en;
        int          kind;
        bit          taken;
        logic [31:0] tgt;

        bif.mem_rdy   = 1'b0;
        bif.mem_rdata = '0;
        bif.unit_done = 1'b0;
        bif.br_taken  = 1'b0;
        bif.br_target = '0;
        m_pc          = RESET_PC;

        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rstn = 1'b1;
        #1;
        reset_checks("reset");

        // Directed cases
        run_inst(32'h0050_0093, K_ALU, 0, 1'b0, '0, 1'b0);
        run_inst(32'h0220_8033, K_MUL, 2, 1'b0, '0, 1'b0);
        run_inst(32'h0000_006F, K_BR, 1, 1'b1, 32'h0000_0100, 1'b0);
        run_inst(32'h0000_0063, K_BR, 0, 1'b1, 32'h0000_0102, 1'b0);
        run_inst(32'hFFFF_FFFF, K_ILL, 0, 1'b0, '0, 1'b0);
        run_inst(32'h0000_006F, K_BR, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_inst(32'h0000_0013, K_ALU, 3, 1'b0, '0, 1'b0);
        run_inst(32'h0000_0013, K_ALU, 0, 1'b0, '0, 1'b1);
        run_inst(32'h0000_2003, K_LSU, int'(TIMEOUT) - 1, 1'b0, '0, 1'b0);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 5);
            taken = (kind == K_BR) ? 1'($urandom_range(0, 1)) : 1'b0;
            tgt   = $urandom;
            tgt[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_inst(mk_inst(kind), kind, $urandom_range(0, 5), taken, tgt, 1'b0);
        end

        // Leave nonzero epc/cause behind, then reset in the middle of WAIT
        run_inst(mk_inst(K_BR), K_BR, 0, 1'b1, 32'h0000_0200, 1'b0);
        run_inst(mk_inst(K_BR), K_BR, 0, 1'b1, 32'h0000_0203, 1'b0);
        start_inst(mk_inst(K_ALU), K_ALU, got_en);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        reset_checks("async_reset");
        sbq.delete();
        m_pc = RESET_PC;
        @(negedge clk); #2;
        rstn = 1'b1;
        #1;
        reset_checks("post_reset");
        run_inst(mk_inst(K_SYS), K_SYS, 1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
- Sequences instruction flow around the instruction decoder: fetches a word from instruction memory and holds it on the decoder's `inst` input.
- Waits out the decoder's one-cycle registered latency on `code`, then issues a one-cycle start pulse to exactly one execution unit.
- Waits for that unit's completion, then advances or redirects the PC.
- Converts illegal encodings, misaligned branch targets and hung units into a trap to a fixed vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- TRAP_VEC, 32'h0000_0010, PC loaded on any trap.
- TIMEOUT, 255, maximum cycles in WAIT before a watchdog trap (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- mem_req  out  1  instruction fetch request
- mem_addr  out  32  fetch address (= pc)
- mem_rdy  in  1  fetch data valid; ignored unless mem_req=1
- mem_rdata  in  32  fetched instruction
- inst  out  32  instruction register, drives decoder `inst`
- code  in  12  registered decoder code; 12'hFFF = illegal
- alu_en, mul_en, lsu_en, br_en, sys_en  out  1 each  one-cycle unit start pulses
- unit_done  in  1  completion from the issued unit
- br_taken  in  1  branch unit redirect, sampled with unit_done
- br_target  in  32  redirect address, sampled with unit_done
- pc  out  32  current instruction address
- trap  out  1  one-cycle pulse on trap entry
- epc  out  32  pc of the faulting instruction
- cause  out  2  0 illegal, 1 misaligned target, 2 watchdog

Behaviour:
- Clock/reset: one clock `clk`; reset `rstn` is asynchronous, active-low. Reset mid-operation aborts any state.
- Reset values:
  - state=FETCH
  - pc=RESET_PC; mem_addr=RESET_PC
  - mem_req=0 for the first cycle after reset, then 1 from FETCH
  - inst=32'h0000_0013 (NOP)
  - all *_en=0, trap=0, epc=0, cause=0, watchdog=0
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_rdy=1: inst<=mem_rdata, mem_req<=0, go DEC.
  - mem_req stays high until mem_rdy.
- DEC: one idle cycle while the decoder registers `code`; go ISSUE.
- ISSUE: classify `code`, pulse one enable for exactly one cycle, clear watchdog, go WAIT.
  - 12'hFFF → no enable; trap, cause=0.
  - code[6:0]=0110011 with code[10]=1 → mul_en.
  - code[6:0] in {0110011, 0010011, 0110111, 0010111} → alu_en.
  - code[6:0] in {0000011, 0100011} → lsu_en.
  - code[6:0] in {1101111, 1100111, 1100011} → br_en.
  - code[6:0] in {1110011, 0011000} → sys_en.
  - Any other value → treated as illegal.
- WAIT: watchdog increments each cycle.
  - unit_done=1 with br_taken=1 and br_target[1:0]=00 → pc<=br_target.
  - unit_done=1 with br_taken=1 and br_target[1:0]≠00 → trap, cause=1.
  - unit_done=1 with br_taken=0 → pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
  - Any non-trap completion → go FETCH.
  - Watchdog reaching TIMEOUT without unit_done → trap, cause=2.
  - unit_done and watchdog expiry in the same cycle → unit_done wins.
- Trap (single cycle, then FETCH): epc<=pc, pc<=TRAP_VEC, trap=1 for one cycle, cause updated. epc/cause hold until the next trap.
- unit_done outside WAIT is ignored.
- Best-case latency per instruction: FETCH (≥1) + DEC + ISSUE + WAIT (≥1) = 4 cycles.

Test Plan:
- Reset, then mem_rdata=32'h00500093 (addi) with mem_rdy on the first request → mem_addr=0; alu_en pulses 2 cycles after the fetch handshake; unit_done → next mem_addr=4.
- mem_rdata=32'h02208033 (mul) → mul_en only; unit_done 3 cycles later → pc=4, no trap.
- Branch: unit_done with br_taken=1 and br_target=0x100 → mem_addr=0x100; repeat with br_target=0x102 → trap, epc=pc, cause=1, mem_addr=0x10.
- mem_rdata=32'hFFFFFFFF (code=FFF) → no enable asserted, trap pulse, cause=0, pc=0x10.
- Withhold unit_done → trap after 255 WAIT cycles, cause=2; separately, unit_done in the expiry cycle → no trap. Assert rstn=0 mid-WAIT → outputs return to reset values immediately.
